// File: rtl/uart_command_receiver.sv
// UART 8N1 receiver and 5-byte command parser (A5 ADDR DH DL CHK).
// Define UART_RX_PARITY_EN to expect an even parity bit before the stop bit.
module uart_command_receiver #(
    parameter int UART_CLK_FREQ  = 100_000_000,
    parameter int UART_BAUDRATE  = 9_200,
    parameter int UART_DATA_SIZE = 8,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_rxBit,
    output logic        o_wrValid,
    output logic [7:0]  o_wrAddr,
    output logic [15:0] o_wrData,
    output logic        o_error,
    output logic [1:0]  o_errorCode,
    output logic        o_busy
);

    localparam int CLKS_PER_BIT = UART_CLK_FREQ / UART_BAUDRATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int BW           = $clog2(UART_DATA_SIZE + 1);
    localparam int TW           = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PARITY, R_STOP
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rx_state_t;
`endif

    typedef enum logic [2:0] {
        P_HDR, P_ADDR, P_DH, P_DL, P_CHK
    } pkt_state_t;

    logic                      r_rxSync1;
    logic                      r_rxSync2;
    logic                      r_rxPrev;
    rx_state_t                 r_rxState;
    rx_state_t                 w_rxNext;
    logic [CW-1:0]             r_clkCnt;
    logic [BW-1:0]             r_bitIdx;
    logic [UART_DATA_SIZE-1:0] r_shift;
    logic                      r_byteValid;
    logic                      r_frameErr;
    logic                      r_parErr;
    logic                      w_fall;
    logic                      w_half;
    logic                      w_tick;
    logic                      w_lastBit;
    logic                      w_sampleData;
    logic                      w_sampleStop;
    logic                      w_parErr;
    logic [7:0]                w_byte;

    pkt_state_t                r_pState;
    pkt_state_t                w_pNext;
    logic [7:0]                r_addr;
    logic [7:0]                r_dh;
    logic [7:0]                r_dl;
    logic [TW-1:0]             r_toCnt;
    logic                      w_timeout;
    logic                      w_chkOk;
    logic                      w_wrValid;
    logic                      w_error;
    logic [1:0]                w_errCode;
    logic                      r_wrValid;
    logic                      r_error;
    logic [1:0]                r_errorCode;
    logic [7:0]                r_wrAddr;
    logic [15:0]               r_wrData;

    assign w_fall    = r_rxPrev & ~r_rxSync2;
    assign w_half    = (r_clkCnt == CW'(HALF_BIT - 1));
    assign w_tick    = (r_clkCnt == CW'(CLKS_PER_BIT - 1));
    assign w_lastBit = (r_bitIdx == BW'(UART_DATA_SIZE - 1));
    assign w_byte    = r_shift[7:0];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_rxState <= R_IDLE;
        else         r_rxState <= w_rxNext;
    end

    always_comb begin
        w_rxNext = r_rxState;
        unique case (r_rxState)
            R_IDLE:  if (w_fall) w_rxNext = R_START;
            R_START: if (w_half) w_rxNext = r_rxSync2 ? R_IDLE : R_DATA;
`ifdef UART_RX_PARITY_EN
            R_DATA:   if (w_tick && w_lastBit) w_rxNext = R_PARITY;
            R_PARITY: if (w_tick) w_rxNext = R_STOP;
`else
            R_DATA:  if (w_tick && w_lastBit) w_rxNext = R_STOP;
`endif
            R_STOP:  if (w_tick) w_rxNext = R_IDLE;
            default: w_rxNext = R_IDLE;
        endcase
    end

    always_comb begin
        w_sampleData = (r_rxState == R_DATA) && w_tick;
        w_sampleStop = (r_rxState == R_STOP) && w_tick;
    end

`ifdef UART_RX_PARITY_EN
    logic r_parBit;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_parBit <= 1'b0;
        else if ((r_rxState == R_PARITY) && w_tick)
            r_parBit <= r_rxSync2;
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_parErr = ^{r_shift, r_parBit};
`else
    assign w_parErr = 1'b0;
`endif

    // Edge detect on the synchronised line also makes a frame error wait for idle high.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rxSync1   <= 1'b1;
            r_rxSync2   <= 1'b1;
            r_rxPrev    <= 1'b1;
            r_clkCnt    <= '0;
            r_bitIdx    <= '0;
            r_shift     <= '0;
            r_byteValid <= 1'b0;
            r_frameErr  <= 1'b0;
            r_parErr    <= 1'b0;
        end else begin
            r_rxSync1 <= i_rxBit;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
            if (r_rxState == R_IDLE || w_rxNext != r_rxState || w_tick)
                r_clkCnt <= '0;
            else
                r_clkCnt <= r_clkCnt + 1'b1;
            if (r_rxState == R_START)
                r_bitIdx <= '0;
            else if (w_sampleData)
                r_bitIdx <= r_bitIdx + 1'b1;
            if (w_sampleData)
                r_shift <= {r_rxSync2, r_shift[UART_DATA_SIZE-1:1]};
            r_byteValid <= w_sampleStop & r_rxSync2 & ~w_parErr;
            r_frameErr  <= w_sampleStop & ~r_rxSync2 & ~w_parErr;
            r_parErr    <= w_sampleStop & w_parErr;
        end
    end

    assign w_timeout = (r_pState != P_HDR) &&
                       (r_toCnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_chkOk   = (w_byte == (r_addr ^ r_dh ^ r_dl));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_pState <= P_HDR;
        else         r_pState <= w_pNext;
    end

    always_comb begin
        w_pNext = r_pState;
        if (r_parErr || r_frameErr) begin
            w_pNext = P_HDR;
        end else if (r_byteValid) begin
            unique case (r_pState)
                P_HDR:   if (w_byte == 8'hA5) w_pNext = P_ADDR;
                P_ADDR:  w_pNext = P_DH;
                P_DH:    w_pNext = P_DL;
                P_DL:    w_pNext = P_CHK;
                P_CHK:   w_pNext = P_HDR;
                default: w_pNext = P_HDR;
            endcase
        end else if (w_timeout) begin
            w_pNext = P_HDR;
        end
    end

    // Priority: parity > frame > checksum > timeout; a byte beats a timeout.
    always_comb begin
        w_wrValid = 1'b0;
        w_error   = 1'b0;
        w_errCode = 2'd0;
        if (r_parErr) begin
            w_error   = 1'b1;
            w_errCode = 2'd3;
        end else if (r_frameErr) begin
            w_error   = 1'b1;
            w_errCode = 2'd0;
        end else if (r_byteValid) begin
            if (r_pState == P_CHK) begin
                w_wrValid = w_chkOk;
                w_error   = ~w_chkOk;
                w_errCode = 2'd1;
            end
        end else if (w_timeout) begin
            w_error   = 1'b1;
            w_errCode = 2'd2;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_dh        <= '0;
            r_dl        <= '0;
            r_toCnt     <= '0;
            r_wrValid   <= 1'b0;
            r_error     <= 1'b0;
            r_errorCode <= 2'd0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
        end else begin
            if (r_byteValid) begin
                if (r_pState == P_ADDR) r_addr <= w_byte;
                if (r_pState == P_DH)   r_dh   <= w_byte;
                if (r_pState == P_DL)   r_dl   <= w_byte;
            end
            if (r_byteValid || r_pState == P_HDR)
                r_toCnt <= '0;
            else
                r_toCnt <= r_toCnt + 1'b1;
            r_wrValid   <= w_wrValid;
            r_error     <= w_error;
            r_errorCode <= w_errCode;
            if (w_wrValid) begin
                r_wrAddr <= r_addr;
                r_wrData <= {r_dh, r_dl};
            end
        end
    end

    assign o_wrValid   = r_wrValid;
    assign o_wrAddr    = r_wrAddr;
    assign o_wrData    = r_wrData;
    assign o_error     = r_error;
    assign o_errorCode = r_errorCode;
    assign o_busy      = (r_pState != P_HDR);

endmodule

// File: tb/tb_uart_command_receiver.sv
// Bench for uart_command_receiver: vector table, corner sequences, random packets.
module tb_uart_command_receiver;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        o_wrValid;
    logic [7:0]  o_wrAddr;
    logic [15:0] o_wrData;
    logic        o_error;
    logic [1:0]  o_errorCode;
    logic        o_busy;

    always #5 clk = ~clk;

    uart_command_receiver #(
        .UART_CLK_FREQ (1_000_000),
        .UART_BAUDRATE (100_000),
        .UART_DATA_SIZE(8),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_rxBit    (rx),
        .o_wrValid  (o_wrValid),
        .o_wrAddr   (o_wrAddr),
        .o_wrData   (o_wrData),
        .o_error    (o_error),
        .o_errorCode(o_errorCode),
        .o_busy     (o_busy)
    );

    typedef struct {
        int          n;
        logic [7:0]  b [6];
        int          nwr;
        int          nerr;
        logic [1:0]  code;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;

    vec_t        vecs [6];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          long_pulses = 0;
    logic        prev_wr = 1'b0;
    logic        prev_err = 1'b0;
    logic        par_flip = 1'b0;
    logic [23:0] wr_q [$];
    logic [1:0]  err_q [$];
    int          err_t [$];
    logic [7:0]  stream [$];
    logic [7:0]  pkt [$];
    logic [23:0] exp_wr [$];
    int          exp_err;
    int          wb, eb, t0, dt;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_wrValid) begin
                if (prev_wr) long_pulses <= long_pulses + 1;
                else wr_q.push_back({o_wrAddr, o_wrData});
            end
            if (o_error) begin
                if (prev_err) long_pulses <= long_pulses + 1;
                else begin
                    err_q.push_back(o_errorCode);
                    err_t.push_back(cyc);
                end
            end
        end
        prev_wr  <= o_wrValid;
        prev_err <= o_error;
    end

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_v;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        send_byte(h, 1'b1);
        send_byte(l, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic check_new(string name, input int nwr, input int nerr);
        check({name, " wr count"}, wr_q.size() - wb, nwr);
        check({name, " err count"}, err_q.size() - eb, nerr);
    endtask

    initial begin
        vecs[0] = '{5, '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h70, 8'h00},
                    1, 0, 2'd0, 8'h12, 16'h3456};
        vecs[1] = '{5, '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h71, 8'h00},
                    0, 1, 2'd1, 8'h12, 16'h3456};
        vecs[2] = '{6, '{8'h33, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h00},
                    1, 0, 2'd0, 8'h01, 16'h0203};
        vecs[3] = '{5, '{8'hA5, 8'hFF, 8'hA5, 8'h5A, 8'h00, 8'h00},
                    1, 0, 2'd0, 8'hFF, 16'hA55A};
        vecs[4] = '{5, '{8'hA5, 8'h80, 8'h01, 8'h02, 8'h00, 8'h00},
                    0, 1, 2'd1, 8'hFF, 16'hA55A};
        vecs[5] = '{6, '{8'h5A, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'hA5},
                    1, 0, 2'd0, 8'hA5, 16'h0000};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset wrValid", o_wrValid, 0);
        check("reset error", o_error, 0);
        check("reset errorCode", o_errorCode, 0);
        check("reset wrAddr", o_wrAddr, 0);
        check("reset wrData", o_wrData, 0);
        check("reset busy", o_busy, 0);
        rst = 1'b0;
        idle(20);

        for (int v = 0; v < 6; v++) begin
            wb = wr_q.size();
            eb = err_q.size();
            for (int j = 0; j < vecs[v].n; j++)
                send_byte(vecs[v].b[j], 1'b1);
            idle(30);
            check_new($sformatf("vec%0d", v), vecs[v].nwr, vecs[v].nerr);
            if (vecs[v].nwr > 0 && wr_q.size() > wb)
                check($sformatf("vec%0d strobe", v), wr_q[wb],
                      {vecs[v].addr, vecs[v].data});
            if (vecs[v].nerr > 0 && err_q.size() > eb)
                check($sformatf("vec%0d code", v), err_q[eb], vecs[v].code);
            check($sformatf("vec%0d addr", v), o_wrAddr, vecs[v].addr);
            check($sformatf("vec%0d data", v), o_wrData, vecs[v].data);
            check($sformatf("vec%0d busy", v), o_busy, 0);
        end

        // Frame error in the address byte, then a good packet.
        wb = wr_q.size();
        eb = err_q.size();
        send_byte(8'hA5, 1'b1);
        idle(5);
        check("frame busy mid", o_busy, 1);
        send_byte(8'h01, 1'b0);
        idle(30);
        check_new("frame", 0, 1);
        if (err_q.size() > eb) check("frame code", err_q[eb], 0);
        check("frame busy", o_busy, 0);
        wb = wr_q.size();
        send_pkt(8'h07, 8'h08, 8'h09, 8'h06);
        idle(30);
        check_new("after frame", 1, 1);
        if (wr_q.size() > wb) check("after frame strobe", wr_q[wb], 24'h070809);

        // Timeout after the address byte.
        wb = wr_q.size();
        eb = err_q.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        t0 = cyc;
        idle(600);
        check_new("timeout", 0, 1);
        if (err_q.size() > eb) begin
            check("timeout code", err_q[eb], 2);
            dt = err_t[eb] - t0;
        end else begin
            dt = -1;
        end
        check("timeout latency", (dt >= 480 && dt <= 520) ? 1 : 0, 1);
        check("timeout busy", o_busy, 0);

        // Short glitch on an idle line.
        wb = wr_q.size();
        eb = err_q.size();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(200);
        check_new("glitch", 0, 0);
        check("glitch busy", o_busy, 0);

        // Asynchronous reset in the middle of the DH byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        #2 rst = 1'b1;
        rx = 1'b1;
        #1;
        check("midreset wrValid", o_wrValid, 0);
        check("midreset wrAddr", o_wrAddr, 0);
        check("midreset wrData", o_wrData, 0);
        check("midreset busy", o_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(150);
        wb = wr_q.size();
        eb = err_q.size();
        send_pkt(8'h22, 8'h33, 8'h44, 8'h55);
        idle(30);
        check_new("post reset", 1, 0);
        if (wr_q.size() > wb) check("post reset strobe", wr_q[wb], 24'h223344);

`ifdef UART_RX_PARITY_EN
        wb = wr_q.size();
        eb = err_q.size();
        send_byte(8'hA5, 1'b1);
        par_flip = 1'b1;
        send_byte(8'h03, 1'b1);
        par_flip = 1'b0;
        idle(30);
        check_new("parity", 0, 1);
        if (err_q.size() > eb) check("parity code", err_q[eb], 3);
        check("parity busy", o_busy, 0);
`endif

        // Random packet stream checked against a byte-queue model.
        stream.delete();
        for (int k = 0; k < 20; k++) begin
            int t;
            logic [7:0] a, h, l, c, j;
            t = $urandom_range(0, 3);
            a = 8'($urandom);
            h = 8'($urandom);
            l = 8'($urandom);
            if (t == 2) a = 8'hA5;
            c = a ^ h ^ l;
            if (t == 1) c = c ^ 8'($urandom_range(1, 255));
            if (t == 0) begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h3C;
                stream.push_back(j);
            end
            stream.push_back(8'hA5);
            stream.push_back(a);
            stream.push_back(h);
            stream.push_back(l);
            stream.push_back(c);
        end
        exp_wr.delete();
        pkt.delete();
        exp_err = 0;
        foreach (stream[i]) begin
            if (pkt.size() != 0 || stream[i] == 8'hA5) begin
                pkt.push_back(stream[i]);
                if (pkt.size() == 5) begin
                    if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4])
                        exp_wr.push_back({pkt[1], pkt[2], pkt[3]});
                    else
                        exp_err++;
                    pkt.delete();
                end
            end
        end
        wb = wr_q.size();
        eb = err_q.size();
        foreach (stream[i]) begin
            send_byte(stream[i], 1'b1);
            idle($urandom_range(0, 20));
        end
        idle(30);
        check_new("random", exp_wr.size(), exp_err);
        foreach (exp_wr[i])
            if (wb + i < wr_q.size())
                check($sformatf("random strobe %0d", i), wr_q[wb + i], exp_wr[i]);
        for (int i = eb; i < err_q.size(); i++)
            check($sformatf("random code %0d", i - eb), err_q[i], 1);

        check("strobe width", long_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
